// File: rtl/posit_acc_ctrl_pkg.sv
// Shared types and constants for the posit accumulator front-end.
// Package name: posit_defines
//   NBITS       posit width
//   POSIT_NAR   NaR bit pattern (sign bit only)
//   acc_state_t controller state encoding
package posit_defines;

  localparam int NBITS = 32;
  localparam logic [NBITS-1:0] POSIT_NAR = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } acc_state_t;

endpackage

// File: rtl/posit_acc_ctrl_pair_sel.sv
// Combinational pairing of the three operand sources: the hold register H,
// a recirculated adder result R and a newly accepted input I.
// Ports:
//   h_valid_i/h_data_i  current hold register
//   r_valid_i/r_data_i  adder result available this cycle
//   i_valid_i/i_data_i  input accepted this cycle
//   issue_o             an operand pair goes to the adder
//   op_a_o/op_b_o       operand pair
//   h_valid_o/h_data_o  next hold register contents
module posit_acc_pair_sel
  import posit_defines::*;
(
  input  logic             h_valid_i,
  input  logic [NBITS-1:0] h_data_i,
  input  logic             r_valid_i,
  input  logic [NBITS-1:0] r_data_i,
  input  logic             i_valid_i,
  input  logic [NBITS-1:0] i_data_i,
  output logic             issue_o,
  output logic [NBITS-1:0] op_a_o,
  output logic [NBITS-1:0] op_b_o,
  output logic             h_valid_o,
  output logic [NBITS-1:0] h_data_o
);

  logic             one_valid;
  logic [NBITS-1:0] one_data;

  // When only one of R/I is present it behaves identically regardless of origin.
  assign one_valid = r_valid_i ^ i_valid_i;
  assign one_data  = r_valid_i ? r_data_i : i_data_i;

  always_comb begin
    issue_o   = 1'b0;
    op_a_o    = h_data_i;
    op_b_o    = one_data;
    h_valid_o = h_valid_i;
    h_data_o  = h_data_i;
    if (r_valid_i && i_valid_i) begin
      // H is left untouched so a pending partial sum keeps waiting for a partner.
      issue_o = 1'b1;
      op_a_o  = r_data_i;
      op_b_o  = i_data_i;
    end else if (one_valid) begin
      if (h_valid_i) begin
        issue_o   = 1'b1;
        h_valid_o = 1'b0;
      end else begin
        h_valid_o = 1'b1;
        h_data_o  = one_data;
      end
    end
  end

endmodule

// File: rtl/posit_acc_ctrl.sv
// Streaming posit accumulator front-end. Accepts a last-tagged vector of posits,
// issues operand pairs to an external ADD_LAT-cycle adder and recirculates its
// results until a single value remains, then presents that value downstream.
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   in_data/in_valid/in_last/in_ready   input vector stream
//   add_in1/add_in2/add_start           registered adder issue
//   add_result/add_inf/add_done         adder return
//   out_data/out_inf/out_valid/out_ready accumulated result
//   out_count                           elements in vector (only with POSIT_ACC_COUNT_EN)
// Build option: define POSIT_ACC_COUNT_EN to add the out_count port and counter.
//
// state | meaning
// FLUSH | ADD_LAT idle cycles letting stale adder results drain out
// ACCUM | accepting input, pairing inputs/results as they arrive
// DRAIN | last input taken, reducing in-flight results to one value
// OUT   | result presented, waiting for downstream handshake
module posit_acc_ctrl
  import posit_defines::*;
#(
  parameter int ADD_LAT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [NBITS-1:0] add_in1,
  output logic [NBITS-1:0] add_in2,
  output logic             add_start,
  input  logic [NBITS-1:0] add_result,
  input  logic             add_inf,
  input  logic             add_done,
  output logic [NBITS-1:0] out_data,
  output logic             out_inf,
  output logic             out_valid,
  input  logic             out_ready
`ifdef POSIT_ACC_COUNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  localparam int FCW = $clog2(ADD_LAT + 1);
  localparam int IFW = $clog2(ADD_LAT + 2);

  acc_state_t       state_q, state_d;
  logic [FCW-1:0]   flush_q, flush_d;
  logic [IFW-1:0]   in_flight_q, in_flight_d;
  logic             h_valid_q, h_valid_d;
  logic [NBITS-1:0] h_data_q, h_data_d;
  logic             add_start_q, add_start_d;
  logic [NBITS-1:0] add_in1_q, add_in1_d;
  logic [NBITS-1:0] add_in2_q, add_in2_d;
  logic             out_valid_q, out_valid_d;
  logic [NBITS-1:0] out_data_q, out_data_d;
  logic             inf_q, inf_d;
`ifdef POSIT_ACC_COUNT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  logic             r_valid, i_valid;
  logic             sel_issue, sel_h_valid;
  logic [NBITS-1:0] sel_a, sel_b, sel_h_data;

  assign in_ready = (state_q == ACCUM);
  // Results arriving with nothing outstanding are leftovers from before a reset.
  assign r_valid  = add_done && (in_flight_q != '0);
  assign i_valid  = in_valid && in_ready;

  posit_acc_pair_sel u_pair_sel (
    .h_valid_i (h_valid_q),
    .h_data_i  (h_data_q),
    .r_valid_i (r_valid),
    .r_data_i  (add_result),
    .i_valid_i (i_valid),
    .i_data_i  (in_data),
    .issue_o   (sel_issue),
    .op_a_o    (sel_a),
    .op_b_o    (sel_b),
    .h_valid_o (sel_h_valid),
    .h_data_o  (sel_h_data)
  );

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    in_flight_d = in_flight_q;
    // Outside ACCUM/DRAIN there are no sources, so the selector just returns H.
    h_valid_d   = sel_h_valid;
    h_data_d    = sel_h_data;
    add_start_d = sel_issue;
    add_in1_d   = add_in1_q;
    add_in2_d   = add_in2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    inf_d       = inf_q | (r_valid & add_inf) | (i_valid & (in_data == POSIT_NAR));
`ifdef POSIT_ACC_COUNT_EN
    cnt_d       = cnt_q;
    if (i_valid && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
`endif

    if (sel_issue) begin
      add_in1_d = sel_a;
      add_in2_d = sel_b;
    end

    if (sel_issue && !r_valid) begin
      in_flight_d = in_flight_q + 1'b1;
    end else if (!sel_issue && r_valid) begin
      in_flight_d = in_flight_q - 1'b1;
    end

    unique case (state_q)
      FLUSH: begin
        if (flush_q == FCW'(ADD_LAT - 1)) begin
          flush_d = '0;
          state_d = ACCUM;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      ACCUM: begin
        if (i_valid && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if ((in_flight_q == '0) && h_valid_q) begin
          out_data_d  = h_data_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          inf_d       = 1'b0;
          h_valid_d   = 1'b0;
`ifdef POSIT_ACC_COUNT_EN
          cnt_d       = 16'd0;
`endif
          state_d     = ACCUM;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FLUSH;
      flush_q     <= '0;
      in_flight_q <= '0;
      h_valid_q   <= 1'b0;
      h_data_q    <= '0;
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      inf_q       <= 1'b0;
`ifdef POSIT_ACC_COUNT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      in_flight_q <= in_flight_d;
      h_valid_q   <= h_valid_d;
      h_data_q    <= h_data_d;
      add_start_q <= add_start_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      inf_q       <= inf_d;
`ifdef POSIT_ACC_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign add_start = add_start_q;
  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_inf   = inf_q;
`ifdef POSIT_ACC_COUNT_EN
  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_posit_acc_ctrl.sv
module tb_posit_acc_ctrl;

  localparam int ADD_LAT = 4;
  localparam logic [31:0] NAR = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] add_in1, add_in2, add_result;
  logic        add_start, add_inf, add_done;
  logic [31:0] out_data;
  logic        out_inf, out_valid, out_ready;
`ifdef POSIT_ACC_COUNT_EN
  logic [15:0] out_count;
`endif

  posit_acc_ctrl #(.ADD_LAT(ADD_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_start  (add_start),
    .add_result (add_result),
    .add_inf    (add_inf),
    .add_done   (add_done),
    .out_data   (out_data),
    .out_inf    (out_inf),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef POSIT_ACC_COUNT_EN
    ,
    .out_count  (out_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        inf;
    int          n;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] vec[$];
  int          tests = 0;
  int          fails = 0;
  int          issue_cnt = 0;
  bit          stall_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- posit32 (es=2) value model ----------------
  function automatic real pow2(input int n);
    real v = 1.0;
    if (n >= 0) repeat (n) v = v * 2.0;
    else repeat (-n) v = v / 2.0;
    return v;
  endfunction

  function automatic real p2r(input logic [31:0] p);
    logic [31:0] q;
    int i, m, k, e;
    real f, w, v;
    logic r;
    if (p == 32'h0) return 0.0;
    q = p[31] ? (~p + 32'd1) : p;
    r = q[30];
    m = 0;
    i = 30;
    while (i >= 0 && q[i] == r) begin m++; i--; end
    i--;
    k = r ? m - 1 : -m;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2;
      if (i >= 0) begin e = e + int'(q[i]); i--; end
    end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (q[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    v = f * pow2(4 * k + e);
    return p[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2p(input real v);
    logic [31:0] res;
    real a, f;
    int s, k, e, pos;
    bit neg;
    if (v == 0.0) return 32'h0;
    neg = (v < 0.0);
    a = neg ? -v : v;
    s = 0;
    while (a >= 2.0) begin a = a / 2.0; s++; end
    while (a < 1.0) begin a = a * 2.0; s--; end
    k = s >>> 2;
    e = s - 4 * k;
    res = 32'h0;
    pos = 30;
    if (k >= 0) begin
      for (int j = 0; j <= k; j++) begin
        if (pos >= 0) res[pos] = 1'b1;
        pos--;
      end
      pos--;
    end else begin
      pos = pos + k;
      if (pos >= 0) res[pos] = 1'b1;
      pos--;
    end
    if (pos >= 0) res[pos] = e[1];
    pos--;
    if (pos >= 0) res[pos] = e[0];
    pos--;
    f = a - 1.0;
    while (pos >= 0) begin
      f = f * 2.0;
      if (f >= 1.0) begin res[pos] = 1'b1; f = f - 1.0; end
      pos--;
    end
    return neg ? (~res + 32'd1) : res;
  endfunction

  // ---------------- adder model (not reset: stale contents persist) ----------------
  logic        pv[ADD_LAT];
  logic [31:0] pr[ADD_LAT];
  logic        pn[ADD_LAT];

  initial begin
    for (int i = 0; i < ADD_LAT; i++) begin pv[i] = 0; pr[i] = 0; pn[i] = 0; end
    add_done = 0;
    add_result = 0;
    add_inf = 0;
  end

  always @(negedge clk) begin
    for (int i = ADD_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pr[i] = pr[i-1];
      pn[i] = pn[i-1];
    end
    pv[0] = add_start;
    pr[0] = 32'h0;
    pn[0] = 1'b0;
    if (add_start === 1'b1) begin
      issue_cnt++;
      if (add_in1 == NAR || add_in2 == NAR) begin
        pr[0] = NAR;
        pn[0] = 1'b1;
      end else begin
        pr[0] = r2p(p2r(add_in1) + p2r(add_in2));
      end
    end
    add_done   = pv[ADD_LAT-1];
    add_result = pr[ADD_LAT-1];
    add_inf    = pn[ADD_LAT-1];
  end

  // ---------------- monitor / scoreboard ----------------
  bit          seen = 0;
  bit          stall_chk = 0;
  int          stall = 0;
  int          issue_base = 0;
  logic [31:0] hd;
  logic        hi;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      seen = 0;
      stall = 0;
      stall_chk = 0;
      out_ready = 0;
      issue_base = issue_cnt;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        hd = out_data;
        hi = out_inf;
        stall_chk = stall_req;
        stall = stall_req ? 5 : $urandom_range(0, 2);
      end else if (stall_chk) begin
        chk("hold_data", out_data, hd);
        chk("hold_inf", 32'(out_inf), 32'(hi));
      end
      if (stall > 0) begin
        out_ready = 0;
        stall--;
      end else begin
        out_ready = 1;
        seen = 0;
        stall_chk = 0;
        if (sbq.size() == 0) begin
          chk("unexpected_output", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_inf", 32'(out_inf), 32'(e.inf));
          chk("add_issues", 32'(issue_cnt - issue_base), 32'(e.n - 1));
`ifdef POSIT_ACC_COUNT_EN
          chk("out_count", 32'(out_count), 32'(e.n));
`endif
        end
        issue_base = issue_cnt;
      end
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  function automatic exp_t model(input int dummy);
    exp_t e;
    real s = 0.0;
    bit nar = 0;
    for (int i = 0; i < vec.size(); i++) begin
      if (vec[i] == NAR) nar = 1;
      else s = s + p2r(vec[i]);
    end
    e.data = nar ? NAR : r2p(s);
    e.inf = nar;
    e.n = dummy + vec.size();
    return e;
  endfunction

  task automatic send_vec(input bit gaps);
    int w;
    sbq.push_back(model(0));
    for (int i = 0; i < vec.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 0;
        end
      end
      @(negedge clk);
      in_valid = 1;
      in_data = vec[i];
      in_last = (i == vec.size() - 1);
      w = 0;
      while (!in_ready && w < 500) begin @(negedge clk); w++; end
      if (w >= 500) chk("in_ready_timeout", 32'(w), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 3000) begin @(negedge clk); w++; end
    if (w >= 3000) chk("idle_timeout", 32'(w), 32'd0);
  endtask

  task automatic measure_flush();
    int zeros = 0;
    while (!in_ready && zeros < 50) begin zeros++; @(negedge clk); end
    chk("flush_len", 32'(zeros), 32'(ADD_LAT));
  endtask

  logic [31:0] pool[12];

  initial begin
    int lat;
    reset_n = 0;
    in_valid = 0;
    in_last = 0;
    in_data = 0;
    pool = '{r2p(1.0), r2p(2.0), r2p(4.0), r2p(0.5), r2p(0.25), r2p(3.0),
             r2p(-1.0), r2p(-2.0), r2p(-0.5), r2p(-3.0), 32'h0, r2p(8.0)};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_add_start", 32'(add_start), 32'd0);
    chk("rst_out_data", out_data, 32'h0);

    // single beat held valid through flush
    in_valid = 1;
    in_data = 32'h4000_0000;
    in_last = 1;
    reset_n = 1;
    measure_flush();
    vec = {32'h4000_0000};
    sbq.push_back(model(0));
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin in_valid = 0; in_last = 0; end
      lat++;
    end while (!out_valid && lat < 50);
    chk("single_lat", 32'(lat), 32'd2);
    wait_idle();

    vec = {32'h4000_0000, 32'hC000_0000};
    send_vec(0);
    wait_idle();

    vec = {};
    repeat (8) vec.push_back(32'h4000_0000);
    send_vec(0);
    wait_idle();

    stall_req = 1;
    vec = {32'h4000_0000, NAR, 32'h4800_0000};
    send_vec(1);
    wait_idle();
    stall_req = 0;

    for (int t = 0; t < 12; t++) begin
      vec = {};
      repeat ($urandom_range(1, 9)) vec.push_back(pool[$urandom_range(0, 11)]);
      send_vec(1);
      wait_idle();
    end

    // reset while draining a long vector
    vec = {};
    repeat (6) vec.push_back(32'h4800_0000);
    send_vec(0);
    @(negedge clk);
    reset_n = 0;
    sbq.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    reset_n = 1;
    measure_flush();
    vec = {32'h4800_0000, 32'h4000_0000};
    send_vec(0);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
